param_dump_sequencer: RTL and testbench



---
 rtl/param_dump_sequencer_if.sv | 36 +++
 rtl/param_dump_sequencer.sv | 161 ++++++++++++++++
 tb/tb_param_dump_sequencer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/param_dump_sequencer_if.sv
// Bus bundle for the parameter dump sequencer: dump request, shared
// register bus (read side) and MIDI TX byte handshake.
//   dump_req/dump_bank : dump request and bank index
//   data_in            : register read data
//   dec_sel/param_adr  : bank select and address, read_write direction
//   tx_data/tx_valid/tx_ready : byte stream to the transmitter
//   busy/dump_done/dump_err   : status
interface param_dump_sequencer_if #(
    parameter int NUM_BANKS  = 6,
    parameter int ADDR_WIDTH = 7
);
    logic                  dump_req;
    logic [2:0]            dump_bank;
    logic [7:0]            data_in;
    logic                  tx_ready;
    logic                  busy;
    logic [NUM_BANKS-1:0]  dec_sel;
    logic [ADDR_WIDTH-1:0] param_adr;
    logic                  read_write;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  dump_done;
    logic                  dump_err;

    modport master (
        output dump_req, dump_bank, data_in, tx_ready,
        input  busy, dec_sel, param_adr, read_write,
        input  tx_data, tx_valid, dump_done, dump_err
    );

    modport slave (
        input  dump_req, dump_bank, data_in, tx_ready,
        output busy, dec_sel, param_adr, read_write,
        output tx_data, tx_valid, dump_done, dump_err
    );
endinterface

// File: rtl/param_dump_sequencer.sv
// Parameter dump sequencer: reads one register bank and streams a framed
// dump (header, 7-bit data bytes, 7-bit checksum) to the MIDI transmitter.
//   reg_clk, reset_reg_N : clock and async active-low reset
//   bus (slave)          : request, register bus and TX handshake signals
module param_dump_sequencer #(
    parameter int NUM_BANKS  = 6,
    parameter int ADDR_WIDTH = 7,
    parameter int BANK_DEPTH = 128,
    parameter int READ_LAT   = 2
) (
    input  logic                   reg_clk,
    input  logic                   reset_reg_N,
    param_dump_sequencer_if.slave  bus
);
    localparam int WW = (READ_LAT > 2) ? $clog2(READ_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_SEL,
        S_WAIT,
        S_CAP,
        S_SEND,
        S_CSUM,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [2:0]            r_bank;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [6:0]            r_acc;
    logic [WW-1:0]         r_wait;
    logic                  r_busy;
    logic [NUM_BANKS-1:0]  r_dec_sel;
    logic [ADDR_WIDTH-1:0] r_param_adr;
    logic                  r_read_write;
    logic [7:0]            r_tx_data;
    logic                  r_tx_valid;
    logic                  r_dump_done;
    logic                  r_dump_err;

    logic                  w_bank_ok;
    logic                  w_last;
    logic [7:0]            w_byte;
    logic [NUM_BANKS-1:0]  w_onehot;

    assign w_bank_ok = ({29'd0, bus.dump_bank} < NUM_BANKS);
    assign w_last    = (r_cnt == ADDR_WIDTH'(BANK_DEPTH - 1));
    // MIDI data bytes carry 7 bits; bit 7 of the register is dropped.
    assign w_byte    = {1'b0, bus.data_in[6:0]};
    assign w_onehot  = NUM_BANKS'(1) << r_bank;

    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            r_state      <= S_IDLE;
            r_bank       <= '0;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_wait       <= '0;
            r_busy       <= 1'b0;
            r_dec_sel    <= '0;
            r_param_adr  <= '0;
            r_read_write <= 1'b0;
            r_tx_data    <= '0;
            r_tx_valid   <= 1'b0;
            r_dump_done  <= 1'b0;
            r_dump_err   <= 1'b0;
        end else begin
            // This block only ever reads the register bus.
            r_read_write <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_dump_done <= 1'b0;
                    r_dump_err  <= 1'b0;
                    if (bus.dump_req) begin
                        if (w_bank_ok) begin
                            r_bank     <= bus.dump_bank;
                            r_cnt      <= '0;
                            r_acc      <= '0;
                            r_busy     <= 1'b1;
                            r_tx_data  <= {5'd0, bus.dump_bank};
                            r_tx_valid <= 1'b1;
                            r_state    <= S_HDR;
                        end else begin
                            r_dump_err <= 1'b1;
                        end
                    end
                end
                S_HDR: begin
                    if (bus.tx_ready) begin
                        r_tx_valid  <= 1'b0;
                        r_dec_sel   <= w_onehot;
                        r_param_adr <= r_cnt;
                        r_state     <= S_SEL;
                    end
                end
                S_SEL: begin
                    // SEL plus READ_LAT-1 WAIT cycles puts CAP exactly
                    // READ_LAT cycles after the address was presented.
                    if (READ_LAT > 1) begin
                        r_wait  <= WW'(READ_LAT - 2);
                        r_state <= S_WAIT;
                    end else begin
                        r_state <= S_CAP;
                    end
                end
                S_WAIT: begin
                    if (r_wait == '0) begin
                        r_state <= S_CAP;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                S_CAP: begin
                    r_tx_data  <= w_byte;
                    r_acc      <= r_acc + w_byte[6:0];
                    r_tx_valid <= 1'b1;
                    r_state    <= S_SEND;
                end
                S_SEND: begin
                    if (bus.tx_ready) begin
                        if (w_last) begin
                            r_dec_sel  <= '0;
                            r_tx_data  <= {1'b0, 7'd0 - r_acc};
                            r_tx_valid <= 1'b1;
                            r_state    <= S_CSUM;
                        end else begin
                            r_tx_valid  <= 1'b0;
                            r_cnt       <= r_cnt + 1'b1;
                            r_param_adr <= r_cnt + 1'b1;
                            r_state     <= S_SEL;
                        end
                    end
                end
                S_CSUM: begin
                    if (bus.tx_ready) begin
                        r_tx_valid  <= 1'b0;
                        r_busy      <= 1'b0;
                        r_dump_done <= 1'b1;
                        r_param_adr <= '0;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_dump_done <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.dec_sel    = r_dec_sel;
    assign bus.param_adr  = r_param_adr;
    assign bus.read_write = r_read_write;
    assign bus.tx_data    = r_tx_data;
    assign bus.tx_valid   = r_tx_valid;
    assign bus.dump_done  = r_dump_done;
    assign bus.dump_err   = r_dump_err;
endmodule

// File: tb/tb_param_dump_sequencer.sv
// Directed bench for param_dump_sequencer: framed streams, masking,
// backpressure, bad requests, reset abort and read latency.
module tb_param_dump_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    logic stall_en;
    logic inj;
    int   stall_cnt;
    int   n_chk = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   sel_bad = 0;
    int   adr_bad = 0;
    int   rw_bad = 0;
    int   stall_bad = 0;
    int   stall_cyc = 0;
    logic [5:0]  sel_or;
    logic [7:0]  q[$];
    logic [7:0]  mem [4];
    logic [12:0] p0, p1, p2;
    logic        pv, pr;
    logic [7:0]  pd;
    logic [6:0]  pa;

    param_dump_sequencer_if #(.NUM_BANKS(6), .ADDR_WIDTH(7)) bus ();

    param_dump_sequencer #(
        .NUM_BANKS(6),
        .ADDR_WIDTH(7),
        .BANK_DEPTH(4),
        .READ_LAT(3)
    ) dut (
        .reg_clk(clk),
        .reset_reg_N(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // Register bus model: data follows the address by exactly 3 cycles.
    // With inj set, a wrong value shows one cycle early.
    always @(posedge clk) begin
        p0 <= {bus.dec_sel, bus.param_adr};
        p1 <= p0;
        p2 <= p1;
    end
    assign bus.data_in = (inj && (p1 != p2)) ? 8'h6E : mem[p2[1:0]];

    // Transmitter: ready always, or 5 stalled cycles per byte.
    always @(posedge clk) begin
        #1;
        if (!stall_en) begin
            bus.tx_ready = 1'b1;
        end else if (bus.tx_valid && !bus.tx_ready) begin
            stall_cnt++;
            if (stall_cnt > 5) bus.tx_ready = 1'b1;
        end else begin
            bus.tx_ready = 1'b0;
            stall_cnt = bus.tx_valid ? 1 : 0;
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            pv = 1'b0;
        end else begin
            if (bus.tx_valid && bus.tx_ready) q.push_back(bus.tx_data);
            if (bus.dump_done) done_cnt++;
            if (bus.dump_err) err_cnt++;
            sel_or = sel_or | bus.dec_sel;
            if (!bus.busy && bus.dec_sel != 6'd0) sel_bad++;
            if (bus.param_adr > 7'd3) adr_bad++;
            if (bus.read_write) rw_bad++;
            if (bus.tx_valid && !bus.tx_ready) stall_cyc++;
            if (pv && !pr && (bus.tx_valid !== 1'b1 ||
                bus.tx_data !== pd || bus.param_adr !== pa))
                stall_bad++;
            pv = bus.tx_valid;
            pr = bus.tx_ready;
            pd = bus.tx_data;
            pa = bus.param_adr;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic start(input logic [2:0] b);
        @(posedge clk);
        #1;
        bus.dump_req  = 1'b1;
        bus.dump_bank = b;
        @(posedge clk);
        #1;
        bus.dump_req  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_tmo"}, 32'(n >= 500), 0);
    endtask

    task automatic chk_stream(input string tag, input logic [7:0] e [6]);
        chk({tag, "_len"}, q.size(), 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("%s_b%0d", tag, i),
                (i < q.size()) ? 32'(q[i]) : 32'hFFFF, 32'(e[i]));
    endtask

    task automatic run_dump(input string tag, input logic [2:0] b,
                            input logic [7:0] e [6]);
        int d0;
        q.delete();
        sel_or = '0;
        d0 = done_cnt;
        start(b);
        wait_done(tag, d0);
        repeat (3) @(negedge clk);
        chk({tag, "_done"}, done_cnt - d0, 1);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_sel"}, 32'(sel_or), 32'(6'd1 << b));
        chk_stream(tag, e);
    endtask

    function automatic logic [31:0] outs();
        return {6'd0, bus.busy, bus.dec_sel, bus.param_adr, bus.read_write,
                bus.tx_data, bus.tx_valid, bus.dump_done, bus.dump_err};
    endfunction

    initial begin
        int e0, d0, n;
        rst_n = 1'b0;
        stall_en = 1'b0;
        inj = 1'b0;
        stall_cnt = 0;
        bus.dump_req = 1'b0;
        bus.dump_bank = 3'd0;
        sel_or = '0;
        mem = '{8'h10, 8'h20, 8'h30, 8'h40};
        repeat (3) @(negedge clk);
        chk("rst_outs", outs(), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        run_dump("basic", 3'd2,
                 '{8'h02, 8'h10, 8'h20, 8'h30, 8'h40, 8'h60});

        mem = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_dump("mask", 3'd5,
                 '{8'h05, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h04});

        mem = '{8'h10, 8'h20, 8'h30, 8'h40};
        stall_en = 1'b1;
        stall_cyc = 0;
        run_dump("stall", 3'd2,
                 '{8'h02, 8'h10, 8'h20, 8'h30, 8'h40, 8'h60});
        chk("stall_cyc", stall_cyc, 30);
        chk("stall_hold", stall_bad, 0);
        stall_en = 1'b0;
        repeat (2) @(negedge clk);

        e0 = err_cnt;
        start(3'd6);
        repeat (2) @(negedge clk);
        chk("err6_cnt", err_cnt - e0, 1);
        chk("err6_busy", 32'(bus.busy), 0);
        chk("err6_sel", 32'(bus.dec_sel), 0);
        start(3'd7);
        repeat (2) @(negedge clk);
        chk("err7_cnt", err_cnt - e0, 2);

        mem = '{8'h01, 8'h02, 8'h03, 8'h04};
        q.delete();
        d0 = done_cnt;
        e0 = err_cnt;
        start(3'd1);
        repeat (8) @(negedge clk);
        start(3'd3);
        wait_done("ign", d0);
        repeat (3) @(negedge clk);
        chk("ign_err", err_cnt - e0, 0);
        chk("ign_done", done_cnt - d0, 1);
        chk_stream("ign", '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h76});

        mem = '{8'h11, 8'h22, 8'h33, 8'h44};
        q.delete();
        d0 = done_cnt;
        start(3'd4);
        n = 0;
        while (!(q.size() == 3 && bus.tx_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_find", 32'(n >= 200), 0);
        chk("rst_pre_v", 32'(bus.tx_valid), 1);
        #2 rst_n = 1'b0;
        #1 chk("rst_async", outs(), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_nodone", done_cnt - d0, 0);
        chk("rst_idle", outs(), 0);
        mem = '{8'h05, 8'h06, 8'h07, 8'h08};
        run_dump("after", 3'd0,
                 '{8'h00, 8'h05, 8'h06, 8'h07, 8'h08, 8'h66});

        inj = 1'b1;
        mem = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
        run_dump("lat", 3'd1,
                 '{8'h01, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h52});
        inj = 1'b0;

        chk("sel_idle", sel_bad, 0);
        chk("adr_max", adr_bad, 0);
        chk("rw_low", rw_bad, 0);
        chk("hold_all", stall_bad, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
